// File: rtl/dragster_spi_slave.sv
// dragster_spi_slave: SPI mode-0 register slave with a 15-entry R/W bank and a
// read-only device ID. All SPI pins are oversampled in the clk domain.
module dragster_spi_slave #(
  parameter logic [7:0] DEVICE_ID = 8'hD5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       reg_wr_stb,
  output logic [3:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic        r_sclkMeta;
  logic        r_sclkSync;
  logic        r_sclkPrev;
  logic        r_csMeta;
  logic        r_csSync;
  logic        r_csPrev;
  logic        r_mosiMeta;
  logic        r_mosiSync;

  logic [1:0]  r_warmCnt;
  logic        r_armed;

  logic [4:0]  r_bitCnt;
  logic [6:0]  r_rx;
  logic [7:0]  r_tx;
  logic        r_miso;
  logic        r_isWrite;
  logic [6:0]  r_addr;
  logic [7:0]  r_regs [0:14];

  logic        r_wrStb;
  logic [3:0]  r_wrAddr;
  logic [7:0]  r_wrData;
  logic        r_frameErr;

  logic        w_sclkRise;
  logic        w_sclkFall;
  logic        w_csFall;
  logic        w_csRise;
  logic [7:0]  w_rxNext;
  logic [7:0]  w_rdData;

  // Two-flop synchronizers plus a history flop for edge detection; reset to the idle bus levels
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclkMeta <= 1'b0;
      r_sclkSync <= 1'b0;
      r_sclkPrev <= 1'b0;
      r_csMeta   <= 1'b1;
      r_csSync   <= 1'b1;
      r_csPrev   <= 1'b1;
      r_mosiMeta <= 1'b0;
      r_mosiSync <= 1'b0;
    end else begin
      r_sclkMeta <= spi_sclk;
      r_sclkSync <= r_sclkMeta;
      r_sclkPrev <= r_sclkSync;
      r_csMeta   <= spi_cs_n;
      r_csSync   <= r_csMeta;
      r_csPrev   <= r_csSync;
      r_mosiMeta <= spi_mosi;
      r_mosiSync <= r_mosiMeta;
    end
  end

  assign w_sclkRise = r_sclkSync & ~r_sclkPrev;
  assign w_sclkFall = ~r_sclkSync & r_sclkPrev;
  assign w_csFall   = ~r_csSync & r_csPrev;
  assign w_csRise   = r_csSync & ~r_csPrev;
  assign w_rxNext   = {r_rx, r_mosiSync};

  // Arm frame start only once the synchronized cs_n has really been seen high after reset,
  // so a chip select that was already low when reset released cannot open a frame
  always_ff @(posedge clk) begin
    if (reset) begin
      r_warmCnt <= 2'd0;
      r_armed   <= 1'b0;
    end else begin
      if (r_warmCnt != 2'd3) begin
        r_warmCnt <= r_warmCnt + 2'd1;
      end
      if (r_warmCnt == 2'd3 && r_csSync) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Read mux keyed by the address bits that complete on the 8th rising edge
  always_comb begin
    w_rdData = 8'h00;
    if (w_rxNext[6:0] == 7'h0F) begin
      w_rdData = DEVICE_ID;
    end else if (w_rxNext[6:0] < 7'h0F) begin
      w_rdData = r_regs[w_rxNext[3:0]];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // FSM next-state logic; a cs_n rise always wins over a coincident sclk edge
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (w_csFall && r_armed) begin
          w_stateNext = SHIFT;
        end
      end
      SHIFT: begin
        if (w_csRise) begin
          w_stateNext = IDLE;
        end else if (w_sclkRise && r_bitCnt == 5'd15) begin
          w_stateNext = WAIT_CS;
        end
      end
      WAIT_CS: begin
        if (w_csRise) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Frame datapath: shifting, header decode, MISO shifting, register commit and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitCnt   <= 5'd0;
      r_rx       <= 7'd0;
      r_tx       <= 8'd0;
      r_miso     <= 1'b0;
      r_isWrite  <= 1'b0;
      r_addr     <= 7'd0;
      r_wrStb    <= 1'b0;
      r_wrAddr   <= 4'd0;
      r_wrData   <= 8'd0;
      r_frameErr <= 1'b0;
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      r_wrStb    <= 1'b0;
      r_frameErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_csFall && r_armed) begin
            r_bitCnt  <= 5'd0;
            r_rx      <= 7'd0;
            r_tx      <= 8'd0;
            r_miso    <= 1'b0;
            r_isWrite <= 1'b0;
            r_addr    <= 7'd0;
          end
        end
        SHIFT: begin
          if (w_csRise) begin
            r_frameErr <= (r_bitCnt != 5'd16);
            r_miso     <= 1'b0;
          end else if (w_sclkRise) begin
            r_rx <= w_rxNext[6:0];
            if (r_bitCnt != 5'd17) begin
              r_bitCnt <= r_bitCnt + 5'd1;
            end
            if (r_bitCnt == 5'd7) begin
              r_isWrite <= w_rxNext[7];
              r_addr    <= w_rxNext[6:0];
              if (!w_rxNext[7]) begin
                r_tx <= w_rdData;
              end
            end
            if (r_bitCnt == 5'd15 && r_isWrite && r_addr < 7'h0F) begin
              r_regs[r_addr[3:0]] <= w_rxNext;
              r_wrStb             <= 1'b1;
              r_wrAddr            <= r_addr[3:0];
              r_wrData            <= w_rxNext;
            end
          end else if (w_sclkFall && r_bitCnt >= 5'd8 && r_bitCnt <= 5'd15) begin
            r_miso <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b0};
          end
        end
        WAIT_CS: begin
          if (w_csRise) begin
            r_frameErr <= (r_bitCnt != 5'd16);
            r_miso     <= 1'b0;
          end else if (w_sclkRise && r_bitCnt != 5'd17) begin
            r_bitCnt <= r_bitCnt + 5'd1;
          end
        end
        default: begin
          r_miso <= 1'b0;
        end
      endcase
    end
  end

  // Output decode: MISO is driven only while the synchronized chip select is active
  always_comb begin
    busy        = (r_state != IDLE);
    spi_miso_oe = ~r_csSync;
    spi_miso    = r_miso & ~r_csSync;
    reg_wr_stb  = r_wrStb;
    reg_wr_addr = r_wrAddr;
    reg_wr_data = r_wrData;
    frame_err   = r_frameErr;
  end

endmodule

// File: tb/tb_dragster_spi_slave.sv
// tb_dragster_spi_slave: directed SPI frames with a write-commit scoreboard and read-back checks.
module tb_dragster_spi_slave;

  localparam int SCLK_HALF = 80;

  logic       clk;
  logic       reset;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       reg_wr_stb;
  logic [3:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       frame_err;
  logic       busy;

  int passCount  = 0;
  int checkCount = 0;
  int stbCount   = 0;
  int errCount   = 0;
  int expStb     = 0;
  int errBefore;

  logic [11:0] wrQ [$];
  logic [7:0]  readQ [$];
  logic [7:0]  rxByte;

  dragster_spi_slave #(.DEVICE_ID(8'hD5)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .reg_wr_stb  (reg_wr_stb),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  // 100 MHz system clock; sclk runs at 1/16 of it
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string tag, input int obs, input int exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Commit monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (reg_wr_stb) begin
      stbCount++;
      if (wrQ.size() > 0) begin
        logic [11:0] e;
        e = wrQ.pop_front();
        checkOutput("wr_addr", int'(reg_wr_addr), int'(e[11:8]));
        checkOutput("wr_data", int'(reg_wr_data), int'(e[7:0]));
      end
    end
    if (frame_err) errCount++;
  end

  // Drive a run of mode-0 sclk cycles; the manager samples MISO on each rising edge
  task automatic clockBits(input logic [15:0] frame, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      if (i < 16) spi_mosi = frame[15 - i];
      else        spi_mosi = 1'b0;
      #(SCLK_HALF);
      spi_sclk = 1'b1;
      if (i >= 8 && i < 16) rxByte[15 - i] = spi_miso;
      #(SCLK_HALF);
      spi_sclk = 1'b0;
    end
  endtask

  // One complete chip-select framed transfer of nEdges sclk cycles
  task automatic applyStimulus(input logic [15:0] frame, input int nEdges);
    rxByte   = 8'h00;
    spi_cs_n = 1'b0;
    #(2 * SCLK_HALF);
    clockBits(frame, 0, nEdges);
    #(SCLK_HALF);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #(3 * SCLK_HALF);
  endtask

  task automatic writeReg(input logic [6:0] addr, input logic [7:0] data);
    if (addr < 7'h0F) begin
      wrQ.push_back({addr[3:0], data});
      expStb++;
    end
    applyStimulus({1'b1, addr, data}, 16);
  endtask

  task automatic readReg(input string tag, input logic [6:0] addr, input logic [7:0] exp);
    logic [7:0] e;
    readQ.push_back(exp);
    applyStimulus({1'b0, addr, 8'h00}, 16);
    e = readQ.pop_front();
    checkOutput(tag, int'(rxByte), int'(e));
  endtask

  initial begin
    reset    = 1'b1;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    rxByte   = 8'h00;
    repeat (4) @(negedge clk);
    checkOutput("rst_busy",   int'(busy),        0);
    checkOutput("rst_stb",    int'(reg_wr_stb),  0);
    checkOutput("rst_err",    int'(frame_err),   0);
    checkOutput("rst_miso",   int'(spi_miso),    0);
    checkOutput("rst_oe",     int'(spi_miso_oe), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    $display("[TB] basic write / read");

    // Write 0x12 to reg 3 with mid-frame status checks
    errBefore = errCount;
    wrQ.push_back({4'h3, 8'h12});
    expStb++;
    spi_cs_n = 1'b0;
    #(2 * SCLK_HALF);
    clockBits(16'h8312, 0, 4);
    checkOutput("busy_mid", int'(busy), 1);
    checkOutput("oe_mid",   int'(spi_miso_oe), 1);
    clockBits(16'h8312, 4, 12);
    #(SCLK_HALF);
    spi_cs_n = 1'b1;
    #(3 * SCLK_HALF);
    checkOutput("busy_after", int'(busy), 0);
    checkOutput("oe_after",   int'(spi_miso_oe), 0);
    checkOutput("wr3_stb",    stbCount, expStb);
    checkOutput("wr3_err",    errCount - errBefore, 0);

    readReg("rd_reg3", 7'h03, 8'h12);
    readReg("rd_id",   7'h0F, 8'hD5);

    $display("[TB] read-only and unimplemented addresses");
    writeReg(7'h0F, 8'h55);
    checkOutput("wrF_nostb", stbCount, expStb);
    readReg("rd_id_again", 7'h0F, 8'hD5);
    readReg("rd_unimpl",   7'h20, 8'h00);
    writeReg(7'h30, 8'hA5);
    checkOutput("wr30_nostb", stbCount, expStb);

    $display("[TB] aborted frame");
    writeReg(7'h04, 8'h33);
    checkOutput("wr4_stb", stbCount, expStb);
    errBefore = errCount;
    applyStimulus(16'h8477, 10);
    checkOutput("abort_err",   errCount - errBefore, 1);
    checkOutput("abort_nostb", stbCount, expStb);
    readReg("rd_reg4", 7'h04, 8'h33);

    $display("[TB] overlong frame");
    errBefore = errCount;
    wrQ.push_back({4'h5, 8'h9C});
    expStb++;
    applyStimulus(16'h859C, 18);
    checkOutput("long_stb", stbCount, expStb);
    checkOutput("long_err", errCount - errBefore, 1);
    readReg("rd_reg5", 7'h05, 8'h9C);

    $display("[TB] reset mid-frame");
    errBefore = errCount;
    spi_cs_n = 1'b0;
    #(2 * SCLK_HALF);
    clockBits(16'h86AB, 0, 12);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rstmid_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    clockBits(16'h8711, 0, 16);
    checkOutput("stale_cs_busy", int'(busy), 0);
    #(SCLK_HALF);
    spi_cs_n = 1'b1;
    #(3 * SCLK_HALF);
    checkOutput("stale_cs_nostb", stbCount, expStb);
    checkOutput("stale_cs_noerr", errCount - errBefore, 0);
    readReg("rd_reg3_cleared", 7'h03, 8'h00);
    writeReg(7'h06, 8'h5A);
    checkOutput("wr6_stb", stbCount, expStb);
    readReg("rd_reg6", 7'h06, 8'h5A);
    readReg("rd_reg7", 7'h07, 8'h00);

    checkOutput("wrQ_drained", wrQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
